// File: rtl/vga_sink_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates, checks
// line/frame lengths, locks onto the stream and checksums each frame.
module vga_sink_monitor #(
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525,
   parameter int H_SYNC  = 97,
   parameter int V_SYNC  = 3
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       vga_clk,
   input  logic       vga_hs,
   input  logic       vga_vs,
   input  logic [7:0] vga_r,
   input  logic [7:0] vga_g,
   input  logic [7:0] vga_b,
   output logic [9:0] x_out,
   output logic [9:0] y_out,
   output logic       pix_valid,
   output logic       locked,
   output logic       frame_done,
   output logic [15:0] frame_sum,
   output logic       err_hline,
   output logic       err_vframe,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t state, state_nxt;
   logic err_seen, seen_nxt;
   logic [26:0] stg1, stg2;
   logic clk_d, hs_q, vs_q;
   logic [9:0] hc, vc, hc_nxt, vc_nxt;
   logic [15:0] acc, pix_sum;
   logic [8:0] cnt_sum;
   logic s_clk, s_hs, s_vs;
   logic [7:0] s_r, s_g, s_b;
   logic strobe, hs_rise, vs_rise, checking, active, hl_bad, vf_bad;

   assign {s_clk, s_hs, s_vs, s_r, s_g, s_b} = stg2;

   // Mid-pixel sample: falling edge of the staged pixel clock
   assign strobe   = clk_d & ~s_clk;
   assign hs_rise  = s_hs & ~hs_q;
   assign vs_rise  = s_vs & ~vs_q;
   assign checking = (state != SEARCH);
   assign active   = ~s_hs & ~s_vs;
   assign hl_bad   = checking & hs_rise & (hc != 10'(H_TOTAL - 1));
   assign vf_bad   = checking & vs_rise & (vc != 10'(V_TOTAL - 1));
   assign hc_nxt   = hs_rise ? 10'd0 : hc + 10'd1;
   assign vc_nxt   = vs_rise ? 10'd0 : (hs_rise ? vc + 10'd1 : vc);
   assign pix_sum  = 16'(s_r) + 16'(s_g) + 16'(s_b);
   assign cnt_sum  = {1'b0, err_count} + 9'(hl_bad) + 9'(vf_bad);
   assign locked   = (state == LOCKED);

   always_comb begin
      state_nxt = state;
      seen_nxt  = err_seen;
      if (strobe) begin
         unique case (state)
            SEARCH: begin
               if (vs_rise) begin
                  state_nxt = MEASURE;
                  seen_nxt  = 1'b0;
               end
            end
            MEASURE: begin
               seen_nxt = err_seen | hl_bad | vf_bad;
               if (vs_rise) begin
                  if (!seen_nxt) state_nxt = LOCKED;
                  seen_nxt = 1'b0;
               end
            end
            LOCKED: begin
               if (hl_bad | vf_bad) state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         stg1 <= '0;
         stg2 <= '0;
         clk_d <= 1'b0;
      end else begin
         stg1 <= {vga_clk, vga_hs, vga_vs, vga_r, vga_g, vga_b};
         stg2 <= stg1;
         clk_d <= s_clk;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state      <= SEARCH;
         err_seen   <= 1'b0;
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         hc         <= '0;
         vc         <= '0;
         acc        <= '0;
         x_out      <= '0;
         y_out      <= '0;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         frame_sum  <= '0;
         err_hline  <= 1'b0;
         err_vframe <= 1'b0;
         err_count  <= '0;
      end else begin
         state      <= state_nxt;
         err_seen   <= seen_nxt;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         err_hline  <= 1'b0;
         err_vframe <= 1'b0;
         if (strobe) begin
            hs_q       <= s_hs;
            vs_q       <= s_vs;
            hc         <= hc_nxt;
            vc         <= vc_nxt;
            err_hline  <= hl_bad;
            err_vframe <= vf_bad;
            err_count  <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
            // Publish only frames that were fully measured without error
            if (vs_rise) begin
               acc <= '0;
               if (state_nxt == LOCKED) begin
                  frame_sum  <= acc;
                  frame_done <= 1'b1;
               end
            end else if (active && checking) begin
               acc <= acc + pix_sum;
            end
            if (active && state == LOCKED) begin
               pix_valid <= 1'b1;
               x_out     <= hc_nxt - 10'(H_SYNC);
               y_out     <= vc_nxt - 10'(V_SYNC);
            end
         end
      end
   end

endmodule

// File: doc/vga_sink_monitor.md
Name: vga_sink_monitor

Overview:
- Receive-side counterpart of the game's VGA output generator.
- Consumes the VGA_CLK/VGA_HS/VGA_VS/RGB stream the display path produces, recovers pixel coordinates and checks line/frame timing.
- Computes a per-frame checksum of active pixels.
- Used as an on-chip self-check and as the observation point for frame-level regression of the maze renderer.

Parameters:
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- H_SYNC, 97, pixel clocks per line with HS high (start of line)
- V_SYNC, 3, lines per frame with VS high (start of frame)

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  async reset
- vga_clk  in  1  pixel clock (CLOCK_50/2, synchronous to CLOCK_50)
- vga_hs  in  1  horizontal sync, active-high
- vga_vs  in  1  vertical sync, active-high
- vga_r  in  8  red
- vga_g  in  8  green
- vga_b  in  8  blue
- x_out  out  10  active-pixel x coordinate
- y_out  out  10  active-pixel y coordinate
- pix_valid  out  1  one-cycle pulse, active pixel sample on x_out/y_out
- locked  out  1  timing verified, coordinates trustworthy
- frame_done  out  1  one-cycle pulse, frame_sum updated
- frame_sum  out  16  checksum of last complete frame
- err_hline  out  1  one-cycle pulse, bad line length
- err_vframe  out  1  one-cycle pulse, bad frame length
- err_count  out  8  saturating error counter

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is CLOCK_50.
- Input staging:
  - vga_clk, vga_hs, vga_vs and RGB pass through an identical 2-flop stage (alignment preserved).
  - Pixel strobe = falling edge of staged vga_clk (previous 1, current 0), i.e. mid-pixel sampling; one strobe per pixel.
  - All logic below advances only on strobe cycles.
- Counters:
  - hc: 10-bit; 0 on HS rising edge, else +1.
  - vc: 10-bit; on VS rising edge → 0; else on HS rising edge → +1.
  - VS has priority when HS and VS rise on the same strobe.
- Checks (only in MEASURE/LOCKED):
  - At HS rise, pre-update hc != H_TOTAL-1 → err_hline.
  - At VS rise, pre-update vc != V_TOTAL-1 → err_vframe.
  - Error pulses are 1 cycle, registered on the strobe cycle.
  - err_count += 1 per pulse (both simultaneously → +2); saturates at 255.
- FSM (SEARCH, MEASURE, LOCKED); transitions are evaluated on strobe cycles:
  - SEARCH: no checks. VS rise → MEASURE.
  - MEASURE: on VS rise, if no error since entering → LOCKED; otherwise stay in MEASURE and clear the error-seen flag.
  - LOCKED: any err_hline/err_vframe → SEARCH, and locked drops the same cycle.
  - locked = 1 only in LOCKED.
- Active pixel: staged HS==0 and VS==0.
  - x = hc - H_SYNC, y = vc - V_SYNC.
  - In LOCKED, pix_valid pulses on the CLOCK_50 cycle after the strobe, with x_out/y_out valid in that cycle.
  - x_out/y_out hold their values otherwise.
- Checksum:
  - acc 16-bit: acc += r+g+b (zero-extended, mod 2^16) for each active pixel, in MEASURE and LOCKED.
  - On VS rise, when leaving MEASURE for LOCKED or staying in LOCKED: frame_sum ← acc and frame_done pulses 1 cycle.
  - acc clears on every VS rise.
  - The sample on the VS-rise strobe is not active, so there is no collision.
- Reset, including mid-frame: state SEARCH, all counters and outputs 0 (x_out, y_out, frame_sum, err_count, all pulses, locked).

Test Plan:
1. Reset asserted mid-frame while LOCKED → every output 0 within the same cycle; after release, locked rises only at the 2nd subsequent VS rise.
2. Nominal source (800×525, HS 97, VS 3) → locked after 2nd VS rise; per frame exactly 703×522 = 366966 pix_valid pulses; first pulse x=0,y=0, last x=702,y=521; no errors.
3. Constant RGB (1,2,3), locked → each frame_done shows frame_sum = 6×366966 mod 65536 = 39108 (0x98C4).
4. One 799-pixel line in a locked frame → err_hline single pulse, err_count=1, locked drops at once, relocks at the 2nd following VS rise.
5. Frame of 524 lines → err_vframe at that VS rise, err_count+1, state SEARCH; no frame_done for that frame.
6. 300 consecutive bad lines → err_count saturates at 255 and holds; HS and VS rising together → vc reset to 0, no spurious err_hline.
